// File: rtl/bias_relu_ctrl.sv
// Sequencer for the bias-add/ReLU SIMD stage: loads one bias per lane from the
// bias buffer, then streams accumulator rows through a registered valid/ready stage.
module bias_relu_ctrl #(
    parameter int ARRAY_N    = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ROW_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
    input  logic [$clog2(ARRAY_N):0]     cfg_num_bias,
    input  logic [ROW_WIDTH-1:0]         cfg_num_rows,
    output logic                         busy,
    output logic                         done,
    output logic                         buf_rd_en,
    output logic [ADDR_WIDTH-1:0]        buf_rd_addr,
    input  logic [OUT_WIDTH-1:0]         buf_rd_data,
    output logic [$clog2(ARRAY_N):0]     simd_w_index,
    output logic [OUT_WIDTH-1:0]         simd_w_data,
    output logic [ARRAY_N-1:0]           simd_w_en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ARRAY_N*OUT_WIDTH-1:0] simd_data_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARRAY_N*OUT_WIDTH-1:0] out_data
);
    localparam int LW = $clog2(ARRAY_N) + 1;
    localparam logic [LW-1:0] LANES = LW'(ARRAY_N);
    localparam logic [ARRAY_N-1:0] LANE0_ONEHOT = {{(ARRAY_N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [LW-1:0]                lane_q, lane_d;
    logic [ADDR_WIDTH-1:0]        base_q, base_d;
    logic [LW-1:0]                nbias_q, nbias_d;
    logic [ROW_WIDTH-1:0]         nrows_q, nrows_d;
    logic [ROW_WIDTH-1:0]         rows_q, rows_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]        rd_addr_q, rd_addr_d;
    logic [ARRAY_N-1:0]           w_en_q, w_en_d;
    logic [LW-1:0]                w_index_q, w_index_d;
    logic                         w_buf_q, w_buf_d;
    logic                         out_valid_q, out_valid_d;
    logic [ARRAY_N*OUT_WIDTH-1:0] out_data_q, out_data_d;

    logic [LW-1:0] lane_next_s;
    logic [LW-1:0] nbias_clamp_s;
    logic          in_ready_s;
    logic          accept_s;

    assign lane_next_s   = lane_q + LW'(1);
    assign nbias_clamp_s = (cfg_num_bias > LANES) ? LANES : cfg_num_bias;
    assign in_ready_s    = (state_q == ST_RUN) && (rows_q < nrows_q) &&
                           (!out_valid_q || out_ready);
    assign accept_s      = in_valid && in_ready_s;

    // Next-state and next-output logic for the load/run sequencer.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        base_d      = base_q;
        nbias_d     = nbias_q;
        nrows_d     = nrows_q;
        rows_d      = rows_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        w_en_d      = '0;
        w_index_d   = w_index_q;
        w_buf_d     = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    base_d    = cfg_base_addr;
                    nbias_d   = nbias_clamp_s;
                    nrows_d   = cfg_num_rows;
                    lane_d    = '0;
                    rows_d    = '0;
                    rd_en_d   = (nbias_clamp_s != '0);
                    rd_addr_d = cfg_base_addr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Lane k is written while lane k+1 is read; the extra pass with
                // lane_q == LANES lets the final write land before leaving LOAD.
                if (lane_q < LANES) begin
                    w_en_d    = LANE0_ONEHOT << lane_q;
                    w_index_d = lane_q;
                    w_buf_d   = (lane_q < nbias_q);
                    lane_d    = lane_next_s;
                    if (lane_next_s < nbias_q) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_q + ADDR_WIDTH'(lane_next_s);
                    end else begin
                        rd_en_d = 1'b0;
                    end
                end else begin
                    state_d = (nrows_q == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    out_data_d  = simd_data_out;
                    out_valid_d = 1'b1;
                    rows_d      = rows_q + ROW_WIDTH'(1);
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (rows_q == nrows_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            base_q      <= '0;
            nbias_q     <= '0;
            nrows_q     <= '0;
            rows_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            w_en_q      <= '0;
            w_index_q   <= '0;
            w_buf_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            base_q      <= base_d;
            nbias_q     <= nbias_d;
            nrows_q     <= nrows_d;
            rows_q      <= rows_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            w_en_q      <= w_en_d;
            w_index_q   <= w_index_d;
            w_buf_q     <= w_buf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign buf_rd_en    = rd_en_q;
    assign buf_rd_addr  = rd_addr_q;
    assign simd_w_index = w_index_q;
    assign simd_w_en    = w_en_q;
    // Buffer data only arrives in the write cycle, so the bias path is a
    // registered-select mux rather than a data register.
    assign simd_w_data  = w_buf_q ? buf_rd_data : '0;
    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;

endmodule

// File: doc/bias_relu_ctrl.md
# bias_relu_ctrl

Sequencer for the bias-add/ReLU SIMD stage at the output of the systolic array. On a start command it streams per-lane bias values from the bias buffer into the SIMD lane registers one lane per cycle, then gates accumulator rows through the stage with a valid/ready handshake and a registered output. It counts rows and pulses `done` when the programmed tile finishes. The controller owns the SIMD write port; the add/ReLU arithmetic stays in the SIMD unit.

## Interface
- `ARRAY_N`, 16: SIMD lane count; power of two, at least 2.
- `OUT_WIDTH`, 32: bits per lane.
- `ADDR_WIDTH`, 10: bias buffer address width.
- `ROW_WIDTH`, 16: row counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: command strobe, sampled only in IDLE.
- `cfg_base_addr`, in, ADDR_WIDTH: bias buffer address of lane 0.
- `cfg_num_bias`, in, $clog2(ARRAY_N)+1: lanes loaded from the buffer (0..ARRAY_N).
- `cfg_num_rows`, in, ROW_WIDTH: rows in the tile.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at tile end.
- `buf_rd_en`, out, 1: bias buffer read strobe.
- `buf_rd_addr`, out, ADDR_WIDTH: bias buffer read address.
- `buf_rd_data`, in, OUT_WIDTH: buffer read data, valid the cycle after `buf_rd_en`.
- `simd_w_index`, out, $clog2(ARRAY_N)+1: lane index to the SIMD.
- `simd_w_data`, out, OUT_WIDTH: bias value to the SIMD.
- `simd_w_en`, out, ARRAY_N: one-hot lane write enable.
- `in_valid`, in, 1: upstream row valid.
- `in_ready`, out, 1: stage accepts a row.
- `simd_data_out`, in, ARRAY_N*OUT_WIDTH: combinational SIMD result for the current row.
- `out_valid`, out, 1: output register holds a row.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, ARRAY_N*OUT_WIDTH: registered row.

## Operation
- States:
  - IDLE: wait for `start`.
  - LOAD: sequence the bias loads.
  - RUN: pass rows through.
  - DONE: signal completion.
- IDLE -> LOAD on `start`. At that edge, latch all `cfg_*` inputs; later `cfg_*` changes have no effect. `start` is ignored in any other state.
- LOAD:
  - Lane counter k runs 0..ARRAY_N-1, one lane per cycle.
  - Read: for k < num_bias, assert `buf_rd_en` with `buf_rd_addr` = base + k, wrapping modulo 2^ADDR_WIDTH.
  - Write, one cycle after the read slot: `simd_w_en` = 1<<k, `simd_w_index` = k, `simd_w_data` = `buf_rd_data` if k < num_bias, else 0.
  - Every lane is therefore rewritten each tile; unused lanes are forced to zero bias.
  - num_bias = 0 writes zero to all lanes with no buffer reads.
  - num_bias > ARRAY_N is treated as ARRAY_N.
- LOAD -> RUN after the write for lane ARRAY_N-1. If num_rows = 0, go LOAD -> DONE instead.
- RUN:
  - `in_ready` = !`out_valid` || `out_ready`; only asserted in RUN and only while rows remain to accept.
  - On `in_valid` && `in_ready`: `out_data` <= `simd_data_out`, `out_valid` <= 1, accepted-row counter increments.
  - On `out_valid` && `out_ready` with no new accept: `out_valid` <= 0.
  - Simultaneous accept and drain keeps `out_valid` = 1 with the new data (full throughput, one row per cycle).
  - After num_rows accepts, `in_ready` = 0.
- RUN -> DONE when num_rows rows have been accepted and the last row drains (`out_valid` && `out_ready`, accept count = num_rows).
- DONE: `done` = 1 for one cycle, then IDLE. `busy` = 0 from IDLE onward.
- `simd_w_en` = 0 outside LOAD. `buf_rd_en` = 0 outside LOAD. `out_data` holds its value while `out_valid` = 1 and `out_ready` = 0.

## Timing
- Reset (`reset_n` = 0 at an edge): state IDLE; counters cleared. All outputs are 0: `busy`, `done`, `buf_rd_en`, `buf_rd_addr`, `simd_w_index`, `simd_w_data`, `simd_w_en`, `in_ready`, `out_valid`, `out_data`.
- Reset mid-operation aborts immediately. No `done` is issued, and partially loaded SIMD biases are left as-is.
- `start` high at edge T: `busy` = 1 from T+1.
  - Read for lane k in cycle T+1+k.
  - Write for lane k in cycle T+2+k.
  - Last write in cycle T+ARRAY_N+1.
  - `in_ready` can first be 1 in cycle T+ARRAY_N+2.
- Row latency: accepted at edge E, visible on `out_data` with `out_valid` from E+1.
- Minimum tile length with no backpressure: ARRAY_N+2 cycles, plus num_rows cycles, plus 1 drain cycle, plus 1 DONE cycle.
- All outputs are registered except `in_ready`, which is combinational from `out_valid`, `out_ready`, state and row count.

## Test plan
1. Reset, then ARRAY_N=16, base=0x010, num_bias=16, buffer[i]=i+1:
   - `simd_w_en` walks 1<<0..1<<15 in cycles T+2..T+17 with data 1..16.
   - Reads at addresses 0x010..0x01F.
2. num_bias=5, base=0x3FE (ADDR_WIDTH=10):
   - Reads at 0x3FE, 0x3FF, 0x000, 0x001, 0x002.
   - Lanes 5..15 are written with 0.
3. num_rows=4, `in_valid` and `out_ready` held high:
   - Four consecutive accepts, one per cycle, each captured on `out_data` one cycle later.
   - `done` pulses once, 2 cycles after the 4th accept.
4. Same tile with `out_ready` low for 3 cycles mid-stream:
   - `in_ready` drops, and `out_data`/`out_valid` hold.
   - No row is lost or duplicated; exactly 4 rows reach the output.
5. num_rows=0, num_bias=0:
   - 16 zero writes, no reads, `in_ready` never asserts.
   - `done` in cycle T+18.
6. `start` pulsed during RUN: ignored. `reset_n` low during LOAD: next cycle all outputs 0 and state IDLE, no `done`; a new `start` then runs a full tile correctly.
